// File: rtl/mux_sweep_pkg.sv
// Shared definitions for the 2:1 mux sweep controller.
//   state_t    : controller FSM states
//   NVEC       : number of test vectors (all {a,b,c} combinations)
//   VEC_W      : vector index width
//   CNT_W      : tally / settle counter width
//   SETTLE_MAX : largest legal SETTLE parameter value
//   mux_exp()  : reference model of the mux under test
package mux_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned NVEC       = 8;
  localparam int unsigned VEC_W      = 3;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SETTLE_MAX = 15;

  // vec = {a,b,c}; c selects b, otherwise a
  function automatic logic mux_exp(input logic [VEC_W-1:0] vec);
    return vec[0] ? vec[1] : vec[2];
  endfunction

endpackage

// File: rtl/mux_sweep_ctrl_settle_timer.sv
// Loadable down-counter used to time the settle window of each vector.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one, stopping at zero
//   value      : current count
//   zero       : count is zero
module settle_timer
  import mux_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - CNT_W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/mux_sweep_ctrl.sv
// Sweep controller for an external 2:1 mux: drives all eight {a,b,c}
// combinations, waits SETTLE cycles per vector, samples z for one cycle and
// tallies passes and fails, remembering the first failing vector.
//   clk, rst_n     : clock, synchronous active-low reset
//   start          : begin a sweep (only honoured in IDLE or DONE)
//   abort          : cancel a sweep in progress
//   a, b, c        : mux drive (c is the select)
//   z              : mux output from the unit under test
//   busy           : sweep in progress (SETTLE or CHECK)
//   done           : sweep complete (DONE)
//   pass_cnt       : vectors that matched
//   fail_cnt       : vectors that did not match (X/Z counts as a fail)
//   fail_seen      : at least one fail this sweep
//   first_fail_vec : {a,b,c} of the first fail
module mux_sweep_ctrl
  import mux_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_seen,
  output logic [VEC_W-1:0] first_fail_vec
);

  localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(NVEC);
  localparam logic [VEC_W-1:0] V_LAST     = VEC_W'(NVEC - 1);

  state_t           state;
  logic [VEC_W-1:0] v;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_dec;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;
  logic             settle_end;
  logic             z_ok;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  // Leave SETTLE on the cycle the count steps 1 -> 0, so exactly SETTLE
  // cycles are spent there; zero is a guard against a stuck window.
  assign settle_end = (state == ST_SETTLE) && (tmr_zero || (tmr_value == CNT_ONE));

  // Case equality so an X/Z return never counts as a pass.
  assign z_ok = (z === mux_exp(v));

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = SETTLE_VAL;
    tmr_dec  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: tmr_load = start;
      ST_SETTLE: begin
        if (abort) begin
          tmr_load = 1'b1;
          tmr_val  = '0;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          tmr_load = 1'b1;
          tmr_val  = '0;
        end else if (v != V_LAST) begin
          tmr_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      v              <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      fail_seen      <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state          <= ST_SETTLE;
            v              <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            fail_seen      <= 1'b0;
            first_fail_vec <= '0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (settle_end) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            if (z_ok) begin
              if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
            end else begin
              if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
              if (!fail_seen) begin
                fail_seen      <= 1'b1;
                first_fail_vec <= v;
              end
            end
            if (v == V_LAST) begin
              state <= ST_DONE;
            end else begin
              v     <= v + VEC_W'(1);
              state <= ST_SETTLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign a    = v[2];
  assign b    = v[1];
  assign c    = v[0];
  assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mux_sweep_ctrl.sv
module tb_mux_sweep_ctrl;

  typedef struct {
    string name;
    int    done;
    int    pass;
    int    fail;
    int    fs;
    int    ffv;
    int    end_cyc;
  } rec_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  // SETTLE=1 instance
  logic       start1, abort1, a1, b1, c1, z1, busy1, done1, fs1;
  logic [3:0] pass1, fail1;
  logic [2:0] ffv1;
  int         mode1;   // 0 correct mux, 1 z stuck at 0, 2 inverted
  // SETTLE=3 instance, always fed an inverted mux
  logic       start3, abort3, a3, b3, c3, z3, busy3, done3, fs3;
  logic [3:0] pass3, fail3;
  logic [2:0] ffv3;

  logic [16:0] o1, o3;
  rec_t q1[$];
  rec_t q3[$];
  rec_t r1, r3;
  logic busy1_prev, busy3_prev;
  int   acc;

  mux_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .a(a1), .b(b1), .c(c1), .z(z1), .busy(busy1), .done(done1),
    .pass_cnt(pass1), .fail_cnt(fail1), .fail_seen(fs1), .first_fail_vec(ffv1)
  );

  mux_sweep_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .a(a3), .b(b3), .c(c3), .z(z3), .busy(busy3), .done(done3),
    .pass_cnt(pass3), .fail_cnt(fail3), .fail_seen(fs3), .first_fail_vec(ffv3)
  );

  assign z1 = (mode1 == 0) ? (c1 ? b1 : a1) :
              (mode1 == 1) ? 1'b0 : ~(c1 ? b1 : a1);
  assign z3 = ~(c3 ? b3 : a3);
  assign o1 = {a1, b1, c1, busy1, done1, pass1, fail1, fs1, ffv1};
  assign o3 = {a3, b3, c3, busy3, done3, pass3, fail3, fs3, ffv3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp_rec(input rec_t r, input int d, input int p, input int f,
                         input int s, input int v);
    chk({r.name, " done"}, d, r.done);
    chk({r.name, " pass_cnt"}, p, r.pass);
    chk({r.name, " fail_cnt"}, f, r.fail);
    chk({r.name, " fail_seen"}, s, r.fs);
    chk({r.name, " first_fail_vec"}, v, r.ffv);
    chk({r.name, " end cycle"}, cyc, r.end_cyc);
  endtask

  task automatic push1(input string nm, input int d, input int p, input int f,
                       input int s, input int v, input int e);
    rec_t r;
    r = '{nm, d, p, f, s, v, e};
    q1.push_back(r);
  endtask

  task automatic push3(input string nm, input int d, input int p, input int f,
                       input int s, input int v, input int e);
    rec_t r;
    r = '{nm, d, p, f, s, v, e};
    q3.push_back(r);
  endtask

  // Monitors: a sweep ends (done, abort or reset) when busy falls.
  initial begin busy1_prev = 1'b0; busy3_prev = 1'b0; end

  always @(negedge clk) begin
    if (busy1_prev && !busy1) begin
      if (q1.size() == 0) begin
        chk("d1 unexpected sweep end", 0, 1);
      end else begin
        r1 = q1.pop_front();
        cmp_rec(r1, int'(done1), int'(pass1), int'(fail1), int'(fs1), int'(ffv1));
      end
    end
    busy1_prev <= busy1;
  end

  always @(negedge clk) begin
    if (busy3_prev && !busy3) begin
      if (q3.size() == 0) begin
        chk("d3 unexpected sweep end", 0, 1);
      end else begin
        r3 = q3.pop_front();
        cmp_rec(r3, int'(done3), int'(pass3), int'(fail3), int'(fs3), int'(ffv3));
      end
    end
    busy3_prev <= busy3;
  end

  task automatic wait1(input int budget);
    for (int i = 0; i < budget && q1.size() != 0; i++) @(negedge clk);
    if (q1.size() != 0) begin
      chk("d1 timeout pending", q1.size(), 0);
      q1.delete();
    end
  endtask

  task automatic wait3(input int budget);
    for (int i = 0; i < budget && q3.size() != 0; i++) @(negedge clk);
    if (q3.size() != 0) begin
      chk("d3 timeout pending", q3.size(), 0);
      q3.delete();
    end
  endtask

  // Pulse start for one cycle; returns the cycle number of the accepting edge.
  task automatic go1(output int a_cyc);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    a_cyc  = cyc;
  endtask

  task automatic go3(output int a_cyc);
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    a_cyc  = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    start1 = 1'b0;
    abort1 = 1'b0;
    start3 = 1'b0;
    abort3 = 1'b0;
    mode1  = 0;
    repeat (3) @(negedge clk);
    chk("reset outputs d1", int'(o1), 0);
    chk("reset outputs d3", int'(o3), 0);

    // start on the very first edge out of reset, correct mux
    rst_n  = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    acc    = cyc;
    push1("correct", 1, 8, 0, 0, 0, acc + 16);
    wait1(60);
    repeat (3) @(negedge clk);
    chk("done hold", int'(done1), 1);
    chk("done hold pass_cnt", int'(pass1), 8);
    chk("done hold fail_cnt", int'(fail1), 0);

    // z stuck at 0
    mode1 = 1;
    go1(acc);
    push1("stuck0", 1, 4, 4, 1, 3, acc + 16);
    wait1(60);

    // abort (with start also high) during vector 5 CHECK
    mode1 = 0;
    go1(acc);
    repeat (11) @(negedge clk);
    abort1 = 1'b1;
    start1 = 1'b1;
    push1("abort v5", 0, 5, 0, 0, 0, acc + 12);
    @(negedge clk);
    abort1 = 1'b0;
    start1 = 1'b0;
    wait1(10);
    repeat (2) @(negedge clk);
    chk("abort idle done", int'(done1), 0);
    chk("abort idle busy", int'(busy1), 0);
    chk("abort frozen pass_cnt", int'(pass1), 5);
    go1(acc);
    push1("after abort", 1, 8, 0, 0, 0, acc + 16);
    wait1(60);

    // SETTLE=3 with inverted mux
    go3(acc);
    push3("inverted s3", 1, 0, 8, 1, 0, acc + 32);
    wait3(100);

    // reset during vector 3 SETTLE
    go1(acc);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    push1("reset mid", 0, 0, 0, 0, 0, acc + 7);
    @(negedge clk);
    chk("reset mid outputs d1", int'(o1), 0);
    chk("reset outputs d3 after done", int'(o3), 0);
    rst_n = 1'b1;
    wait1(5);
    go1(acc);
    push1("after reset", 1, 8, 0, 0, 0, acc + 16);
    wait1(60);

    // start held high: ignored while busy, restarts from DONE
    mode1 = 1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    acc = cyc;
    push1("held first", 1, 4, 4, 1, 3, acc + 16);
    mode1 = 1;
    push1("held restart", 1, 4, 4, 1, 3, acc + 33);
    repeat (17) @(negedge clk);
    chk("restart busy", int'(busy1), 1);
    chk("restart cleared pass_cnt", int'(pass1), 0);
    chk("restart cleared fail_cnt", int'(fail1), 0);
    chk("restart cleared fail_seen", int'(fs1), 0);
    start1 = 1'b0;
    wait1(60);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
